// File: rtl/blockmem_pkg.sv
// ============================================================================
// Module      : blockmem_pkg
// Description : Shared types and constants for the blockmem read-stream front
//               end: FSM state encoding and read-buffer sizing.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blockmem_pkg;

  // Read-side burst FSM. Explicit 1-bit encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  // Output buffer depth. Two entries cover the one-cycle memory latency plus
  // one beat of back-pressure, which is what sustains one beat per cycle.
  localparam int C_RDBUF_DEPTH = 2;

  // Occupancy counter width (must represent 0..C_RDBUF_DEPTH).
  localparam int C_RDBUF_CNTW  = $clog2(C_RDBUF_DEPTH + 1);

endpackage : blockmem_pkg

`default_nettype wire

// File: rtl/blockmem_skid_fifo.sv
// ============================================================================
// Module      : blockmem_skid_fifo
// Description : Two-entry synchronous FIFO used as the read-data output
//               buffer. Simultaneous push and pop is legal in every state,
//               including full (the popped slot is refilled in the same
//               cycle).
// Ports       : clk, resetn     - clock, asynchronous active-low reset
//               push, din       - write strobe and data
//               pop             - read strobe (head consumed this cycle)
//               dout            - head entry
//               cnt/empty/full  - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blockmem_skid_fifo
  import blockmem_pkg::*;
#(
  parameter int G_WIDTH = 33
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [G_WIDTH-1:0]      din,
  input  logic                    pop,
  output logic [G_WIDTH-1:0]      dout,
  output logic [C_RDBUF_CNTW-1:0] cnt,
  output logic                    empty,
  output logic                    full
);

  // Pointers are single bits because the buffer is exactly two entries deep;
  // toggling a pointer is the wrap.
  logic [G_WIDTH-1:0]      mem_q [0:C_RDBUF_DEPTH-1];
  logic [G_WIDTH-1:0]      mem_d [0:C_RDBUF_DEPTH-1];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [C_RDBUF_CNTW-1:0] cnt_q, cnt_d;

  logic do_push;
  logic do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == C_RDBUF_CNTW'(C_RDBUF_DEPTH));
  assign cnt   = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle, so stored data is never overwritten.
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    cnt_d = cnt_q + C_RDBUF_CNTW'(do_push) - C_RDBUF_CNTW'(do_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule : blockmem_skid_fifo

`default_nettype wire

// File: rtl/blockmem_rd_stream.sv
// ============================================================================
// Module      : blockmem_rd_stream
// Description : Read-side front end for blockmem_2p port B (single clock).
//               Accepts a burst request, issues incrementing wrap-around
//               reads, captures the data after the one-cycle memory latency
//               and presents it as a valid/ready stream with a last flag.
// Ports       : clk, resetn                      - clock, async active-low rst
//               req_valid/req_ready/addr/len      - burst request handshake
//               mem_en/mem_addr/mem_dout          - memory port B
//               m_valid/m_ready/m_data/m_last     - output stream
//               busy                              - any burst activity pending
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blockmem_rd_stream
  import blockmem_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_LENWIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  // burst request
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [G_ADDRWIDTH-1:0] req_addr,
  input  logic [G_LENWIDTH-1:0]  req_len,
  // memory port B
  output logic                   mem_en,
  output logic [G_ADDRWIDTH-1:0] mem_addr,
  input  logic [G_DATAWIDTH-1:0] mem_dout,
  // output stream
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [G_DATAWIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   busy
);

  localparam int C_OUTW = C_RDBUF_CNTW + 1;

  rd_state_t               state_q, state_d;
  logic [G_ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [G_LENWIDTH-1:0]   beats_q, beats_d;
  logic                    inflight_q, inflight_d;
  logic                    last_tag_q, last_tag_d;
  // Held low through reset and for the first edge after it, so req_ready is
  // not advertised while the block is still held in reset.
  logic                    alive_q, alive_d;

  logic                    issue;
  logic                    issue_last;
  logic                    credit_ok;
  logic                    pop;
  logic [C_OUTW-1:0]       outstanding;

  logic [C_RDBUF_CNTW-1:0] fifo_cnt;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [G_DATAWIDTH:0]    fifo_dout;

  // --------------------------------------------------------------------------
  // Credit: beats that will occupy the buffer once the in-flight read lands,
  // after this cycle's pop. A new read may only be issued while that is below
  // the buffer depth, so every captured word has a slot waiting for it.
  // --------------------------------------------------------------------------
  assign pop         = m_valid & m_ready;
  assign outstanding = C_OUTW'(fifo_cnt) + C_OUTW'(inflight_q) - C_OUTW'(pop);
  assign credit_ok   = (outstanding < C_OUTW'(C_RDBUF_DEPTH)) & ~(fifo_full & ~pop);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      last_tag_q <= last_tag_d;
      alive_q    <= alive_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (issue_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (request handshake and memory port)
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = alive_q;
      BURST:   issue     = credit_ok;
      default: ;
    endcase
    issue_last = issue & (beats_q == '0);
    mem_en     = issue;
    mem_addr   = issue ? addr_q : '0;
  end

  // --------------------------------------------------------------------------
  // Address / beat counters and read-latency tracking
  // --------------------------------------------------------------------------
  always_comb begin
    addr_d     = addr_q;
    beats_d    = beats_q;
    alive_d    = 1'b1;
    inflight_d = issue;
    last_tag_d = issue_last;

    if (req_valid && req_ready) begin
      addr_d  = req_addr;
      beats_d = req_len;
    end else if (issue) begin
      // Depth need not be a power of two, so wrap explicitly.
      if (addr_q == G_ADDRWIDTH'(G_MEMDEPTH - 1)) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + G_ADDRWIDTH'(1);
      end
      beats_d = beats_q - G_LENWIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer: captures {last, data} the cycle the memory output is valid
  // --------------------------------------------------------------------------
  blockmem_skid_fifo #(
    .G_WIDTH (G_DATAWIDTH + 1)
  ) u_rdbuf (
    .clk    (clk),
    .resetn (resetn),
    .push   (inflight_q),
    .din    ({last_tag_q, mem_dout}),
    .pop    (pop),
    .dout   (fifo_dout),
    .cnt    (fifo_cnt),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_dout[G_DATAWIDTH-1:0];
  // The head slot keeps its old contents after draining; qualify the flag.
  assign m_last  = fifo_dout[G_DATAWIDTH] & m_valid;
  assign busy    = (state_q == BURST) | inflight_q | ~fifo_empty;

endmodule : blockmem_rd_stream

`default_nettype wire

// File: tb/tb_blockmem_rd_stream.sv
// ============================================================================
// Module      : tb_blockmem_rd_stream
// Description : Directed self-checking bench for blockmem_rd_stream with a
//               behavioural one-cycle-latency memory model on port B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blockmem_rd_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int LW    = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  always #5 clk = ~clk;

  blockmem_rd_stream #(
    .G_DATAWIDTH (DW),
    .G_MEMDEPTH  (DEPTH),
    .G_ADDRWIDTH (AW),
    .G_LENWIDTH  (LW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  // Memory model: registered read, one cycle latency.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) mem_dout <= mem[mem_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, sampled mid-cycle (handshakes complete on the next edge).
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];
  int            addrs [$];
  int            issued  = 0;
  int            popped  = 0;
  int            max_out = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      issued <= 0;
      popped <= 0;
    end else begin
      if (mem_en) addrs.push_back(int'(mem_addr));
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
      if (issued + int'(mem_en) - popped - int'(m_valid && m_ready) > max_out)
        max_out <= issued + int'(mem_en) - popped - int'(m_valid && m_ready);
      issued <= issued + int'(mem_en);
      popped <= popped + int'(m_valid && m_ready);
    end
  end

  // Expected beats, built from the request and the memory contents.
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];
  int            exp_a [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns one time unit after the accepting edge.
  task automatic send_req(input int a, input int l);
    logic acc;
    bit   done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_len   = LW'(l);
    for (int i = 0; i < 200; i++) begin
      #1;
      acc = req_ready;
      step();
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!done) chk("req_accept_timeout", 64'(done), 64'd1);
    for (int k = 0; k <= l; k++) begin
      exp_a.push_back((a + k) % DEPTH);
      exp_d.push_back(mem[(a + k) % DEPTH]);
      exp_l.push_back(k == l);
    end
  endtask

  task automatic wait_beats(input string tag, input int base, input int n);
    for (int i = 0; i < 400; i++) begin
      if (got_d.size() - base >= n) break;
      step();
    end
    chk(tag, 64'(got_d.size() - base), 64'(n));
  endtask

  task automatic check_stream(input string tag, input int gbase, input int abase);
    chk({tag, "_nbeats"}, 64'(got_d.size() - gbase), 64'(exp_d.size()));
    chk({tag, "_naddr"}, 64'(addrs.size() - abase), 64'(exp_a.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (gbase + i < got_d.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 64'(got_d[gbase + i]), 64'(exp_d[i]));
        chk($sformatf("%s_last%0d", tag, i), 64'(got_l[gbase + i]), 64'(exp_l[i]));
      end
      if (abase + i < addrs.size())
        chk($sformatf("%s_addr%0d", tag, i), 64'(addrs[abase + i]), 64'(exp_a[i]));
    end
    exp_d.delete();
    exp_l.delete();
    exp_a.delete();
  endtask

  task automatic single_beat(input string tag);
    int gb, ab;
    mem[5]  = 32'hA5A5_0005;
    m_ready = 1'b1;
    gb = got_d.size();
    ab = addrs.size();
    send_req(5, 0);
    #1;
    chk({tag, "_t1_mem_en"}, 64'(mem_en), 64'd1);
    chk({tag, "_t1_mem_addr"}, 64'(mem_addr), 64'd5);
    chk({tag, "_t1_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_t1_m_valid"}, 64'(m_valid), 64'd0);
    step();
    chk({tag, "_t2_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_t2_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_t2_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_t2_busy"}, 64'(busy), 64'd1);
    step();
    chk({tag, "_t3_m_valid"}, 64'(m_valid), 64'd1);
    chk({tag, "_t3_m_data"}, 64'(m_data), 64'hA5A5_0005);
    chk({tag, "_t3_m_last"}, 64'(m_last), 64'd1);
    step();
    chk({tag, "_t4_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_t4_busy"}, 64'(busy), 64'd0);
    check_stream(tag, gb, ab);
  endtask

  initial begin
    int gb, ab, lastcnt;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    m_ready   = 1'b0;

    // ---- reset values ----
    repeat (2) step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    step();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // ---- single beat ----
    single_beat("single");

    // ---- streaming 16 beats, no bubbles ----
    for (int i = 0; i < 16; i++) mem[i] = 32'(i);
    m_ready = 1'b1;
    gb = got_d.size();
    ab = addrs.size();
    send_req(0, 15);
    wait_beats("stream_done", gb, 16);
    repeat (3) step();
    for (int i = 1; i < 16; i++)
      if (gb + i < got_c.size())
        chk($sformatf("stream_gap%0d", i), 64'(got_c[gb + i] - got_c[gb + i - 1]), 64'd1);
    check_stream("stream", gb, ab);

    // ---- wrap at non-power-of-two depth ----
    mem[998] = 32'h1111_0998;
    mem[999] = 32'h1111_0999;
    mem[0]   = 32'h1111_0000;
    mem[1]   = 32'h1111_0001;
    gb = got_d.size();
    ab = addrs.size();
    send_req(998, 3);
    wait_beats("wrap_done", gb, 4);
    repeat (3) step();
    check_stream("wrap", gb, ab);

    // ---- back-pressure ----
    for (int i = 0; i < 8; i++) mem[100 + i] = 32'hB000_0000 | 32'(i);
    gb = got_d.size();
    ab = addrs.size();
    send_req(100, 7);
    for (int i = 0; i < 4; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b0;
    repeat (10) step();
    chk("bp_hold_mem_en", 64'(mem_en), 64'd0);
    chk("bp_hold_m_valid", 64'(m_valid), 64'd1);
    chk("bp_hold_outstanding", 64'(issued - popped), 64'd2);
    for (int i = 0; i < 300; i++) begin
      if (got_d.size() - gb >= 8) break;
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    wait_beats("bp_done", gb, 8);
    repeat (3) step();
    chk("bp_max_outstanding_le2", 64'(max_out <= 2), 64'd1);
    check_stream("bp", gb, ab);

    // ---- back-to-back bursts ----
    for (int i = 0; i < 4; i++) mem[200 + i] = 32'hC000_0000 | 32'(i);
    for (int i = 0; i < 3; i++) mem[300 + i] = 32'hD000_0000 | 32'(i);
    m_ready = 1'b1;
    gb = got_d.size();
    ab = addrs.size();
    send_req(200, 3);
    send_req(300, 2);
    wait_beats("b2b_done", gb, 7);
    repeat (3) step();
    lastcnt = 0;
    for (int i = gb; i < got_l.size(); i++) lastcnt += int'(got_l[i]);
    chk("b2b_last_pulses", 64'(lastcnt), 64'd2);
    check_stream("b2b", gb, ab);

    // ---- reset mid-burst ----
    for (int i = 0; i < 8; i++) mem[400 + i] = 32'hE000_0000 | 32'(i);
    m_ready = 1'b1;
    gb = got_d.size();
    send_req(400, 7);
    wait_beats("mid_beats", gb, 3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_m_data", 64'(m_data), 64'd0);
    chk("mid_rst_m_last", 64'(m_last), 64'd0);
    exp_d.delete();
    exp_l.delete();
    exp_a.delete();
    step();
    step();
    resetn = 1'b1;
    gb = got_d.size();
    repeat (8) step();
    chk("mid_rst_no_stale", 64'(got_d.size() - gb), 64'd0);
    chk("mid_rst_idle_valid", 64'(m_valid), 64'd0);
    single_beat("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_blockmem_rd_stream

`default_nettype wire
